// File: rtl/box_line_feeder_pkg.sv
// Shared types and constants for the three-line box filter feeder.
package box_line_feeder_pkg;

    localparam int unsigned WORD_W  = 64;
    localparam int unsigned STATE_W = 2;

    // Feeder phases: fill the two history rows, then stream triples.
    localparam logic [STATE_W-1:0] ST_PRIME0 = 2'd0;
    localparam logic [STATE_W-1:0] ST_PRIME1 = 2'd1;
    localparam logic [STATE_W-1:0] ST_STREAM = 2'd2;

    typedef logic [WORD_W-1:0] word_t;

    // One column-aligned output triple: row n-2, row n-1, row n.
    typedef struct packed {
        word_t l1;
        word_t l2;
        word_t l3;
    } triple_t;

endpackage

// File: rtl/box_line_buf.sv
// One row of pixel words: single synchronous write port, asynchronous read.
module box_line_buf
    import box_line_feeder_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  word_t             wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output word_t             rdata_o
);

    word_t mem_q [DEPTH];

    // Storage write; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/box_line_feeder.sv
// Turns a raster pixel stream into column-aligned (n-2, n-1, n) row triples.
module box_line_feeder
    import box_line_feeder_pkg::*;
#(
    parameter int unsigned LINE_WORDS  = 64,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned FRAME_LINES = 480,
    parameter int unsigned ROW_W       = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pcie_str_data_valid,
    output logic              o_pcie_str_ack,
    input  logic [WORD_W-1:0] i_pcie_str_data,
    output logic              o_line1_data_valid,
    output logic [WORD_W-1:0] o_line1_data,
    input  logic              i_line1_data_ack,
    output logic              o_line2_data_valid,
    output logic [WORD_W-1:0] o_line2_data,
    input  logic              i_line2_data_ack,
    output logic              o_line3_data_valid,
    output logic [WORD_W-1:0] o_line3_data,
    input  logic              i_line3_data_ack,
    output logic              o_frame_done
);

    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(LINE_WORDS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(FRAME_LINES - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [ADDR_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               sel_q, sel_d;
    logic               valid_q, valid_d;
    triple_t            out_q, out_d;
    logic               last_q, last_d;
    logic               done_q, done_d;

    logic  ack_c, in_xfer_c, out_xfer_c, col_end_c;
    logic  we_old_c, we_new_c, we0_c, we1_c;
    word_t rd0_c, rd1_c, older_c, newer_c;

    // Handshake decode; STREAM only takes a word when the output slot frees.
    assign out_xfer_c = valid_q & i_line1_data_ack & i_line2_data_ack & i_line3_data_ack;
    assign ack_c      = !i_rst && ((state_q != ST_STREAM) || !valid_q || out_xfer_c);
    assign in_xfer_c  = i_pcie_str_data_valid & ack_c;
    assign col_end_c  = (col_q == COL_LAST);

    // Ping-pong selection: sel picks which buffer holds the older row.
    assign older_c = sel_q ? rd1_c : rd0_c;
    assign newer_c = sel_q ? rd0_c : rd1_c;
    assign we0_c   = (we_old_c & ~sel_q) | (we_new_c & sel_q);
    assign we1_c   = (we_old_c & sel_q) | (we_new_c & ~sel_q);

    box_line_buf #(.DEPTH(LINE_WORDS), .ADDR_W(ADDR_W)) u_buf0 (
        .clk_i   (i_clk),
        .we_i    (we0_c),
        .waddr_i (col_q),
        .wdata_i (i_pcie_str_data),
        .raddr_i (col_q),
        .rdata_o (rd0_c)
    );

    box_line_buf #(.DEPTH(LINE_WORDS), .ADDR_W(ADDR_W)) u_buf1 (
        .clk_i   (i_clk),
        .we_i    (we1_c),
        .waddr_i (col_q),
        .wdata_i (i_pcie_str_data),
        .raddr_i (col_q),
        .rdata_o (rd1_c)
    );

    // Next-state, counters, buffer writes and output register loading.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        sel_d    = sel_q;
        valid_d  = valid_q;
        out_d    = out_q;
        last_d   = last_q;
        done_d   = out_xfer_c & last_q;
        we_old_c = 1'b0;
        we_new_c = 1'b0;

        if (out_xfer_c) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        if (in_xfer_c) begin
            col_d = col_end_c ? '0 : col_q + ADDR_W'(1);
            if (col_end_c) begin
                row_d = row_q + ROW_W'(1);
            end
            case (state_q)
                ST_PRIME0: begin
                    we_old_c = 1'b1;
                    if (col_end_c) state_d = ST_PRIME1;
                end
                ST_PRIME1: begin
                    we_new_c = 1'b1;
                    if (col_end_c) state_d = ST_STREAM;
                end
                ST_STREAM: begin
                    we_old_c = 1'b1;
                    valid_d  = 1'b1;
                    out_d    = '{l1: older_c, l2: newer_c, l3: i_pcie_str_data};
                    last_d   = col_end_c && (row_q == ROW_LAST);
                    if (col_end_c) begin
                        sel_d = ~sel_q;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = ST_PRIME0;
                        end
                    end
                end
                default: state_d = ST_PRIME0;
            endcase
        end else if (state_q != ST_PRIME0 && state_q != ST_PRIME1 && state_q != ST_STREAM) begin
            state_d = ST_PRIME0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_PRIME0;
            col_q   <= '0;
            row_q   <= '0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            out_q   <= out_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign o_pcie_str_ack     = ack_c;
    assign o_line1_data_valid = valid_q;
    assign o_line2_data_valid = valid_q;
    assign o_line3_data_valid = valid_q;
    assign o_line1_data       = out_q.l1;
    assign o_line2_data       = out_q.l2;
    assign o_line3_data       = out_q.l3;
    assign o_frame_done       = done_q;

endmodule

// File: tb/tb_box_line_feeder.sv
// Randomized bench for box_line_feeder against a frame-image reference model.
module tb_box_line_feeder;

    localparam int LW = 4;
    localparam int FL = 5;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ack;
    logic [63:0] i_data;
    logic        v1, v2, v3;
    logic [63:0] d1, d2, d3;
    logic        a1, a2, a3;
    logic        o_fd;

    always #5 clk = ~clk;

    box_line_feeder #(.LINE_WORDS(LW), .ADDR_W(2), .FRAME_LINES(FL), .ROW_W(3)) dut (
        .i_clk                 (clk),
        .i_rst                 (i_rst),
        .i_pcie_str_data_valid (i_valid),
        .o_pcie_str_ack        (o_ack),
        .i_pcie_str_data       (i_data),
        .o_line1_data_valid    (v1),
        .o_line1_data          (d1),
        .i_line1_data_ack      (a1),
        .o_line2_data_valid    (v2),
        .o_line2_data          (d2),
        .i_line2_data_ack      (a2),
        .o_line3_data_valid    (v3),
        .o_line3_data          (d3),
        .i_line3_data_ack      (a3),
        .o_frame_done          (o_fd)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: whole-frame image, expected triple queue.
    typedef struct {
        logic [63:0] l1;
        logic [63:0] l2;
        logic [63:0] l3;
        bit          last;
    } trip_t;

    trip_t       q[$];
    logic [63:0] img [FL][LW];
    int          mrow = 0, mcol = 0;
    bit          fd_pend = 0, acc_flag = 0;
    int          n_out = 0, n_fd = 0, n_acc = 0;
    bit          cap_arm = 0;
    logic [63:0] cap1 = '0, cap2 = '0, cap3 = '0;

    // Monitor at the falling edge: decide this cycle's transfers and compare.
    always @(negedge clk) begin
        bit    ev, oxfer, eack, ixfer;
        trip_t t;
        if (i_rst) begin
            check("ack_in_reset", 64'(o_ack), 64'd0);
            q.delete();
            mrow = 0; mcol = 0; fd_pend = 0; acc_flag = 0;
        end else begin
            check("frame_done", 64'(o_fd), 64'(fd_pend));
            if (o_fd) n_fd++;
            ev = (q.size() != 0);
            check("valid1", 64'(v1), 64'(ev));
            check("valid2", 64'(v2), 64'(ev));
            check("valid3", 64'(v3), 64'(ev));
            oxfer   = ev && a1 && a2 && a3;
            fd_pend = 1'b0;
            if (ev) begin
                check("line1", d1, q[0].l1);
                check("line2", d2, q[0].l2);
                check("line3", d3, q[0].l3);
            end
            if (oxfer) begin
                fd_pend = q[0].last;
                if (cap_arm) begin
                    cap1 = d1; cap2 = d2; cap3 = d3;
                    cap_arm = 1'b0;
                end
                void'(q.pop_front());
                n_out++;
            end
            eack = (mrow < 2) || !ev || oxfer;
            check("in_ack", 64'(o_ack), 64'(eack));
            ixfer    = i_valid && eack;
            acc_flag = ixfer;
            if (ixfer) begin
                n_acc++;
                img[mrow][mcol] = i_data;
                if (mrow >= 2) begin
                    t.l1   = img[mrow-2][mcol];
                    t.l2   = img[mrow-1][mcol];
                    t.l3   = i_data;
                    t.last = (mrow == FL-1) && (mcol == LW-1);
                    q.push_back(t);
                end
                mcol++;
                if (mcol == LW) begin
                    mcol = 0;
                    mrow++;
                    if (mrow == FL) mrow = 0;
                end
            end
        end
    end

    // Stimulus generator: word = frame*256 + row*16 + col.
    int g_frame = 0, g_row = 0, g_col = 0;

    task automatic step(input int vp, input int p1, input int p2, input int p3, input bit rst);
        @(posedge clk);
        #1;
        if (acc_flag) begin
            g_col++;
            if (g_col == LW) begin
                g_col = 0;
                g_row++;
                if (g_row == FL) begin
                    g_row = 0;
                    g_frame++;
                end
            end
        end
        i_rst   = rst;
        i_valid = (int'($urandom_range(0, 99)) < vp);
        i_data  = 64'(g_frame * 256 + g_row * 16 + g_col);
        a1      = (int'($urandom_range(0, 99)) < p1);
        a2      = (int'($urandom_range(0, 99)) < p2);
        a3      = (int'($urandom_range(0, 99)) < p3);
    endtask

    task automatic run_to(input int fr, input int r, input int c, input int vp, input int ap);
        int n;
        n = 0;
        while (!(g_frame == fr && g_row == r && g_col == c) && n < 3000) begin
            step(vp, ap, ap, ap, 1'b0);
            n++;
        end
        check("reach_target", 64'(n < 3000), 64'd1);
    endtask

    task automatic drain(input int n);
        repeat (n) step(0, 100, 100, 100, 1'b0);
    endtask

    initial begin
        int base_out, base_fd, base_acc;
        i_rst = 1'b1; i_valid = 1'b0; i_data = '0; a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
        step(0, 0, 0, 0, 1'b1);
        step(0, 0, 0, 0, 1'b1);
        g_frame = 0; g_row = 0; g_col = 0;

        // Two back-to-back frames, continuous input, acks always high.
        cap_arm = 1'b1; base_out = n_out; base_fd = n_fd;
        run_to(2, 0, 0, 100, 100);
        drain(6);
        check("a_out_count", 64'(n_out - base_out), 64'd24);
        check("a_fd_count", 64'(n_fd - base_fd), 64'd2);
        check("a_first_l1", cap1, 64'h00);
        check("a_first_l2", cap2, 64'h10);
        check("a_first_l3", cap3, 64'h20);

        // Line-2 ack stall during row 3.
        run_to(2, 3, 1, 100, 100);
        repeat (3) step(100, 100, 0, 100, 1'b0);
        check("stall_ack", 64'(o_ack), 64'd0);
        repeat (2) step(100, 100, 0, 100, 1'b0);
        run_to(3, 0, 0, 100, 100);
        drain(6);

        // Random input gaps and per-line ack stalls over three frames.
        base_fd = n_fd;
        run_to(6, 0, 0, 60, 70);
        drain(10);
        check("c_fd_count", 64'(n_fd - base_fd), 64'd3);

        // Acks low in STREAM: only one word may be accepted.
        run_to(7, 2, 0, 100, 100);
        base_acc = n_acc;
        repeat (6) step(100, 0, 0, 0, 1'b0);
        step(0, 0, 0, 0, 1'b0);
        check("d_one_accept", 64'(n_acc - base_acc), 64'd1);
        run_to(8, 0, 0, 100, 100);
        drain(6);

        // Reset in the middle of row 3, then a fresh frame.
        run_to(9, 3, 2, 100, 100);
        step(100, 100, 100, 100, 1'b1);
        g_frame = 0; g_row = 0; g_col = 0;
        cap_arm = 1'b1; base_out = n_out; base_fd = n_fd;
        step(100, 100, 100, 100, 1'b0);
        check("e_valid_after_rst", 64'(v1), 64'd0);
        check("e_fd_after_rst", 64'(o_fd), 64'd0);
        run_to(1, 0, 0, 100, 100);
        drain(6);
        check("e_out_count", 64'(n_out - base_out), 64'd12);
        check("e_fd_count", 64'(n_fd - base_fd), 64'd1);
        check("e_first_l1", cap1, 64'h00);
        check("e_first_l2", cap2, 64'h10);
        check("e_first_l3", cap3, 64'h20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
